// File: rtl/cdb_arb.sv
// Round-robin arbiter packing up to four completions per cycle onto the 4-slot CDB.
// Define CDB_ARB_REG_EN to flop the slot outputs (one cycle of CDB latency).
module cdb_arb #(
  parameter int unsigned NUM_REQ = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   fu_valid,
  input  logic [7*NUM_REQ-1:0] fu_pr_tag,
  input  logic [5*NUM_REQ-1:0] fu_ar_tag,
  output logic [NUM_REQ-1:0]   fu_grant,
  output logic [3:0]           cdb_broadcast,
  output logic [6:0]           cdb_pr_tag0,
  output logic [6:0]           cdb_pr_tag1,
  output logic [6:0]           cdb_pr_tag2,
  output logic [6:0]           cdb_pr_tag3,
  output logic [4:0]           cdb_ar_tag0,
  output logic [4:0]           cdb_ar_tag1,
  output logic [4:0]           cdb_ar_tag2,
  output logic [4:0]           cdb_ar_tag3
);

  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [3:0]      bcast_c;
  logic [3:0][6:0] pr_c;
  logic [3:0][4:0] ar_c;
  logic [3:0]      sum;
  logic [2:0]      idx, cnt, last;

  // Scan from rr_ptr with wrap; sum never exceeds 14 since both terms are below 8.
  always_comb begin
    fu_grant = '0;
    bcast_c  = '0;
    pr_c     = '0;
    ar_c     = '0;
    rr_ptr_d = rr_ptr_q;
    sum      = '0;
    idx      = '0;
    cnt      = '0;
    last     = '0;
    if (!reset) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        sum = {1'b0, rr_ptr_q} + 4'(k);
        if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
        idx = sum[2:0];
        if (fu_valid[idx] && (cnt < 3'd4)) begin
          fu_grant[idx]     = 1'b1;
          bcast_c[cnt[1:0]] = 1'b1;
          pr_c[cnt[1:0]]    = fu_pr_tag[7*idx +: 7];
          ar_c[cnt[1:0]]    = fu_ar_tag[5*idx +: 5];
          cnt               = cnt + 3'd1;
          last              = idx;
        end
      end
      if (cnt != 3'd0) rr_ptr_d = (last == 3'(NUM_REQ - 1)) ? 3'd0 : last + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= 3'd0;
    else       rr_ptr_q <= rr_ptr_d;
  end

`ifdef CDB_ARB_REG_EN
  logic [3:0]      bcast_q;
  logic [3:0][6:0] pr_q;
  logic [3:0][4:0] ar_q;

  // Combinational slots are already zero in reset and idle cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      bcast_q <= '0;
      pr_q    <= '0;
      ar_q    <= '0;
    end else begin
      bcast_q <= bcast_c;
      pr_q    <= pr_c;
      ar_q    <= ar_c;
    end
  end

  always_comb begin
    cdb_broadcast = bcast_q;
    cdb_pr_tag0   = pr_q[0];
    cdb_pr_tag1   = pr_q[1];
    cdb_pr_tag2   = pr_q[2];
    cdb_pr_tag3   = pr_q[3];
    cdb_ar_tag0   = ar_q[0];
    cdb_ar_tag1   = ar_q[1];
    cdb_ar_tag2   = ar_q[2];
    cdb_ar_tag3   = ar_q[3];
  end
`else
  always_comb begin
    cdb_broadcast = bcast_c;
    cdb_pr_tag0   = pr_c[0];
    cdb_pr_tag1   = pr_c[1];
    cdb_pr_tag2   = pr_c[2];
    cdb_pr_tag3   = pr_c[3];
    cdb_ar_tag0   = ar_c[0];
    cdb_ar_tag1   = ar_c[1];
    cdb_ar_tag2   = ar_c[2];
    cdb_ar_tag3   = ar_c[3];
  end
`endif

endmodule

// File: tb/tb_cdb_arb.sv
// Bench for cdb_arb: scoreboard of expected CDB slot contents plus inline grant checks.
module tb_cdb_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  fu_valid;
  logic [41:0] fu_pr_tag;
  logic [29:0] fu_ar_tag;
  logic [5:0]  fu_grant;
  logic [3:0]  cdb_broadcast;
  logic [6:0]  cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3;
  logic [4:0]  cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3;

  typedef struct packed {
    logic [3:0]  b;
    logic [27:0] pr;
    logic [19:0] ar;
  } cdb_t;

  cdb_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [6:0] pr_t[6];
  logic [4:0] ar_t[6];
  int         ptr_m = 0;

  cdb_arb #(.NUM_REQ(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .fu_valid      (fu_valid),
    .fu_pr_tag     (fu_pr_tag),
    .fu_ar_tag     (fu_ar_tag),
    .fu_grant      (fu_grant),
    .cdb_broadcast (cdb_broadcast),
    .cdb_pr_tag0   (cdb_pr_tag0),
    .cdb_pr_tag1   (cdb_pr_tag1),
    .cdb_pr_tag2   (cdb_pr_tag2),
    .cdb_pr_tag3   (cdb_pr_tag3),
    .cdb_ar_tag0   (cdb_ar_tag0),
    .cdb_ar_tag1   (cdb_ar_tag1),
    .cdb_ar_tag2   (cdb_ar_tag2),
    .cdb_ar_tag3   (cdb_ar_tag3)
  );

  always #5 clock = ~clock;

  // Reference arbiter: rotate through requesters starting at ptr.
  function automatic cdb_t model(input logic [5:0] v, input int ptr,
                                 output logic [5:0] g, output int nptr);
    cdb_t c;
    int   n;
    int   i;
    c    = '0;
    g    = '0;
    n    = 0;
    nptr = ptr;
    for (int j = 0; j < 6; j++) begin
      i = (ptr + j) % 6;
      if (v[i] && n < 4) begin
        g[i]            = 1'b1;
        c.b[n]          = 1'b1;
        c.pr[7*n +: 7]  = pr_t[i];
        c.ar[5*n +: 5]  = ar_t[i];
        n++;
        nptr = (i + 1) % 6;
      end
    end
    return c;
  endfunction

  task automatic drive(input logic [5:0] v, input logic rst, output logic [5:0] g_m);
    cdb_t c;
    int   np;
    @(negedge clock);
    reset    = rst;
    fu_valid = v;
    for (int i = 0; i < 6; i++) begin
      fu_pr_tag[7*i +: 7] = pr_t[i];
      fu_ar_tag[5*i +: 5] = ar_t[i];
    end
    if (rst) begin
      g_m = '0;
      c   = '0;
      np  = 0;
    end else begin
      c = model(v, ptr_m, g_m, np);
    end
    ptr_m = np;
    exp_q.push_back(c);
  endtask

  // Slot monitor: combinational build samples late in the cycle, registered build after the edge.
  initial begin
    cdb_t got, want;
    forever begin
`ifdef CDB_ARB_REG_EN
      @(posedge clock);
      #1;
`else
      @(negedge clock);
      #2;
`endif
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = '{b: cdb_broadcast,
                 pr: {cdb_pr_tag3, cdb_pr_tag2, cdb_pr_tag1, cdb_pr_tag0},
                 ar: {cdb_ar_tag3, cdb_ar_tag2, cdb_ar_tag1, cdb_ar_tag0}};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL cdb_slots at %0t: got b=%b pr=%h ar=%h want b=%b pr=%h ar=%h",
                   $time, got.b, got.pr, got.ar, want.b, want.pr, want.ar);
        end
      end
    end
  end

  task automatic test_reset;
    logic [5:0] g;
    drive(6'b111111, 1'b1, g);
    #1;
    total++;
    if (fu_grant !== 6'b000000) begin
      bad++;
      $display("FAIL reset_grant: got %b want 000000", fu_grant);
    end
  endtask

  task automatic test_two_req;
    logic [5:0] g;
    pr_t[0] = 7'd40; ar_t[0] = 5'd3;
    pr_t[2] = 7'd41; ar_t[2] = 5'd7;
    drive(6'b000101, 1'b0, g);
    #1;
    total++;
    if (fu_grant !== 6'b000101) begin
      bad++;
      $display("FAIL two_req_grant: got %b want 000101", fu_grant);
    end
    drive(6'b111111, 1'b0, g);
    #1;
    total++;
    if (fu_grant !== 6'b111001) begin
      bad++;
      $display("FAIL ptr3_grant: got %b want 111001", fu_grant);
    end
  endtask

  task automatic test_all_valid;
    logic [5:0] g;
    logic [5:0] want[2];
    want[0] = 6'b001111;
    want[1] = 6'b110011;
    drive(6'b000000, 1'b1, g);
    for (int c = 0; c < 2; c++) begin
      drive(6'b111111, 1'b0, g);
      #1;
      total++;
      if (fu_grant !== want[c]) begin
        bad++;
        $display("FAIL all_valid_grant%0d: got %b want %b", c, fu_grant, want[c]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [5:0] g;
    logic [5:0] vals[5];
    vals[0] = 6'b001100;
    vals[1] = 6'b010000;
    vals[2] = 6'b100010;
    vals[3] = 6'b000000;
    vals[4] = 6'b001011;
    for (int s = 0; s < 5; s++) begin
      drive(vals[s], 1'b0, g);
      #1;
      total++;
      if (fu_grant !== vals[s]) begin
        bad++;
        $display("FAIL wrap_grant%0d: got %b want %b", s, fu_grant, vals[s]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [5:0] g;
    drive(6'b000111, 1'b1, g);
    #1;
    total++;
    if (fu_grant !== 6'b000000) begin
      bad++;
      $display("FAIL reset_mid_grant: got %b want 000000", fu_grant);
    end
    drive(6'b111111, 1'b0, g);
    #1;
    total++;
    if (fu_grant !== 6'b001111) begin
      bad++;
      $display("FAIL after_reset_grant: got %b want 001111", fu_grant);
    end
  endtask

  task automatic test_single;
    logic [5:0] g;
    pr_t[3] = 7'd90; ar_t[3] = 5'd12;
    drive(6'b001000, 1'b0, g);
    #1;
    total++;
    if (fu_grant !== 6'b001000) begin
      bad++;
      $display("FAIL single_grant: got %b want 001000", fu_grant);
    end
    drive(6'b000000, 1'b0, g);
    #1;
    total++;
    if (fu_grant !== 6'b000000) begin
      bad++;
      $display("FAIL idle_grant: got %b want 000000", fu_grant);
    end
  endtask

  task automatic test_fairness;
    logic [5:0] pend;
    logic [5:0] g;
    int         wt[6];
    pend = '0;
    for (int i = 0; i < 6; i++) wt[i] = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 6; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          pr_t[i] = 7'($urandom_range(127, 0));
          ar_t[i] = 5'($urandom_range(31, 0));
        end
      end
      drive(pend, 1'b0, g);
      #1;
      total++;
      if (fu_grant !== g) begin
        bad++;
        $display("FAIL fair_grant%0d: got %b want %b", c, fu_grant, g);
      end
      for (int i = 0; i < 6; i++) begin
        if (pend[i]) begin
          if (fu_grant[i]) begin
            pend[i] = 1'b0;
            wt[i]   = 0;
          end else begin
            wt[i]++;
            total++;
            if (wt[i] >= 2) begin
              bad++;
              $display("FAIL fair_wait req%0d: waited %0d cycles, limit 1", i, wt[i]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    fu_valid  = '0;
    fu_pr_tag = '0;
    fu_ar_tag = '0;
    for (int i = 0; i < 6; i++) begin
      pr_t[i] = 7'(10 + i);
      ar_t[i] = 5'(i);
    end
    test_reset();
    test_two_req();
    test_all_valid();
    test_wrap();
    test_reset_mid();
    test_single();
    test_fairness();
    @(negedge clock);
    fu_valid = '0;
    repeat (3) @(negedge clock);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
